macc_err_inject_array: RTL
==========================

// Module: macc_err_inject_array
// PURPOSE
//  Multi-channel signed multiply-accumulate array with deterministic, threshold-driven fault insertion.
//  Successor to the single-lane MAC/error-insertion datapath.
//  Generalised in channel count, operand width and accumulator width; adds a valid handshake,
//  sticky overflow flags and round-robin bit-flip injection across channels.
//  Sits under mac_top-class wrappers as the device under fault study.
// PARAMETERS
//  CH     4   number of independent MAC lanes
//  IN_W   16  signed operand width (a, b)
//  ACC_W  40  signed accumulator width; must be >= 2*IN_W
//  CNT_W  16  width of err_count
// PORTS
//  clk            in   1             rising-edge clock
//  rst            in   1             asynchronous, active-low reset
//  ce             in   1             global clock enable; low freezes every register
//  sload          in   1             1 = load product into accumulator (discard history)
//  in_valid       in   1             a/b/sload qualify this cycle
//  a              in   CH*IN_W       lane c operand at [c*IN_W +: IN_W], signed
//  b              in   CH*IN_W       lane c operand, signed
//  err_threshold  in   32            accumulation events between injections; 0 = never
//  err_bit_sel    in   $clog2(ACC_W) accumulator bit to flip
//  accum_out      out  CH*ACC_W      lane accumulators, registered
//  out_valid      out  1             accum_out updated this cycle
//  ovf            out  CH            sticky signed-overflow per lane
//  err_flag       out  CH            1-cycle pulse: lane c was corrupted in this result
//  err_count      out  CNT_W         total injections, saturating
// BEHAVIOUR
//  - Reset (rst=0, async): accum_out=0, out_valid=0, ovf=0, err_flag=0, err_count=0.
//    Also clears event counter, lane pointer and pipeline valids. In-flight data is dropped.
//  - Stage 1, when ce&in_valid: prod[c] <= a[c]*b[c] (signed, 2*IN_W); s1_valid/s1_sload captured.
//    When ce & !in_valid: s1_valid <= 0.
//  - Stage 2, when ce&s1_valid: acc[c] <= s1_sload ? sext(prod) : acc[c] + sext(prod), wrapping mod 2^ACC_W.
//    out_valid <= ce ? s1_valid : out_valid.
//  - Latency: 2 ce-enabled cycles from in_valid to out_valid. Throughput: 1 per cycle. No backpressure.
//  - ce=0: all state, including out_valid/err_flag, holds its value. No event is counted.
//  - ovf[c]: set when the add's operands share a sign and the result's sign differs.
//    Cleared on a stage-2 sload update of that lane. A simultaneous sload wins; a load cannot overflow.
//  - err_flag is cleared the cycle after a pulse (when ce=1).
// CONFIGURATION
//  MACC_ERR_INJECT_EN defined:
//  - 32-bit event counter evt increments on each stage-2 update.
//  - When err_threshold!=0 and evt+1 >= err_threshold:
//    - bit err_bit_sel of the new acc[ptr] is inverted before it is stored. Corruption persists into later sums.
//    - err_flag[ptr] pulses with that out_valid.
//    - evt <= 0; ptr <= (ptr+1) mod CH.
//    - err_count += 1, saturating at all-ones.
//  - sload and injection in the same update: load first, then flip.
//  - err_bit_sel >= ACC_W: no flip, no pulse, no count; evt still resets and ptr still advances.
//  - err_threshold lowered below evt: injection fires on the next update.
//  MACC_ERR_INJECT_EN undefined: no counter or pointer logic; err_flag=0 and err_count=0 constant.
//  Datapath is bit-identical to the enabled build with err_threshold=0.
// STRUCTURE
//  - Package macc_err_pkg: default widths, lane-slice function, sign-extend function,
//    ovf-detect function.
//  - Sub-module macc_err_lane (one per lane, generate loop): product register, accumulator,
//    ovf flag; inputs flip_en and flip_bit.
//  - Top module: valid pipeline, event counter, round-robin pointer, err_count.
// TESTING
//  1. CH=1; sload with a=1,b=29, then a=1,b=29 x4 accumulate, err_threshold=0 ->
//     accum_out 29,58,87,116,145 on consecutive out_valid; err_flag never set.
//  2. CH=2, a=1,b=1 both lanes, first sload, err_threshold=3, err_bit_sel=4 -> 3rd result:
//     lane0 = 3^16 = 19 with err_flag=01; 6th result: lane0 = 22, lane1 = 6^16 = 22,
//     err_flag=10; err_count=2.
//  3. IN_W=16, ACC_W=32: accumulate a=32767,b=32767 repeatedly -> ovf[0] set on first wrap,
//     stays set; next sload clears it.
//  4. Hold ce=0 for 5 cycles mid-stream with in_valid=1 -> outputs frozen; sequence resumes
//     with no lost or duplicated sample.
//  5. Drop rst for 1 cycle between clock edges during accumulation -> all outputs 0 immediately;
//     first result after release reflects only post-reset inputs.
//  6. Build without MACC_ERR_INJECT_EN, rerun test 2 stimulus -> lanes 1..6 clean; err_flag=0, err_count=0.

Source files
------------

// File: rtl/macc_err_pkg.sv
// Shared widths and helpers for the multi-lane MAC / fault-injection array.
package macc_err_pkg;

    localparam int unsigned DEF_CH    = 4;
    localparam int unsigned DEF_IN_W  = 16;
    localparam int unsigned DEF_ACC_W = 40;
    localparam int unsigned DEF_CNT_W = 16;
    localparam int unsigned MAX_W     = 128;

    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned w);
        return lane * w;
    endfunction

    // Replicates bit w-1 of v into every bit above it.
    function automatic logic [MAX_W-1:0] sext(input logic [MAX_W-1:0] v, input int unsigned w);
        logic [MAX_W-1:0] r;
        r = v;
        for (int unsigned i = w; i < MAX_W; i++) r[i] = v[w-1];
        return r;
    endfunction

    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/macc_err_lane.sv
// One MAC lane: registered signed product, wrapping accumulator, sticky overflow, bit flip.
module macc_err_lane
    import macc_err_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned BIT_W = $clog2(DEF_ACC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_en,
    input  logic             s2_en,
    input  logic             sload,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             flip_en,
    input  logic [BIT_W-1:0] flip_bit,
    output logic [ACC_W-1:0] acc,
    output logic             ovf
);

    logic [2*IN_W-1:0] a_ext, b_ext, prod;
    logic [ACC_W-1:0]  prod_ext, sum, next_acc;

    // Low 2*IN_W bits of the product of sign-extended operands equal the signed product.
    assign a_ext    = (2*IN_W)'(sext(MAX_W'(a), IN_W));
    assign b_ext    = (2*IN_W)'(sext(MAX_W'(b), IN_W));
    assign prod_ext = ACC_W'(sext(MAX_W'(prod), 2*IN_W));
    assign sum      = acc + prod_ext;

    always_comb begin
        next_acc = sload ? prod_ext : sum;
        if (flip_en) next_acc = next_acc ^ (ACC_W'(1) << flip_bit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= '0;
            acc  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (s1_en) prod <= a_ext * b_ext;
            if (s2_en) begin
                acc <= next_acc;
                ovf <= sload ? 1'b0 : (ovf | add_ovf(acc[ACC_W-1], prod_ext[ACC_W-1], sum[ACC_W-1]));
            end
        end
    end

endmodule

// File: rtl/macc_err_inject_array.sv
// Multi-lane signed MAC array with threshold-driven round-robin bit-flip injection.
// Injection logic is present only when MACC_ERR_INJECT_EN is defined.
module macc_err_inject_array
    import macc_err_pkg::*;
#(
    parameter int unsigned CH    = DEF_CH,
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       sload,
    input  logic                       in_valid,
    input  logic [CH*IN_W-1:0]         a,
    input  logic [CH*IN_W-1:0]         b,
    input  logic [31:0]                err_threshold,
    input  logic [$clog2(ACC_W)-1:0]   err_bit_sel,
    output logic [CH*ACC_W-1:0]        accum_out,
    output logic                       out_valid,
    output logic [CH-1:0]              ovf,
    output logic [CH-1:0]              err_flag,
    output logic [CNT_W-1:0]           err_count
);

    localparam int unsigned BIT_W = $clog2(ACC_W);

    logic          s1_valid, s1_sload, s2_en;
    logic [CH-1:0] flip_vec;

    assign s2_en = ce & s1_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_sload  <= 1'b0;
            out_valid <= 1'b0;
        end else if (ce) begin
            s1_valid  <= in_valid;
            if (in_valid) s1_sload <= sload;
            out_valid <= s1_valid;
        end
    end

`ifdef MACC_ERR_INJECT_EN
    localparam int unsigned PTR_W = (CH > 1) ? $clog2(CH) : 1;

    logic [31:0]      evt;
    logic [PTR_W-1:0] ptr;
    logic             inject, bit_ok;

    // 33-bit compare so evt+1 cannot wrap past a large threshold.
    assign inject = s2_en && (err_threshold != '0) &&
                    (({1'b0, evt} + 33'd1) >= {1'b0, err_threshold});
    assign bit_ok = 32'(err_bit_sel) < ACC_W;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt       <= '0;
            ptr       <= '0;
            err_count <= '0;
            err_flag  <= '0;
        end else if (ce) begin
            err_flag <= flip_vec;
            if (s2_en) begin
                if (inject) begin
                    evt <= '0;
                    ptr <= (ptr == PTR_W'(CH - 1)) ? '0 : ptr + 1'b1;
                    if (bit_ok && (err_count != '1)) err_count <= err_count + 1'b1;
                end else begin
                    evt <= evt + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_flip
        assign flip_vec[c] = inject && bit_ok && (ptr == PTR_W'(c));
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{err_threshold, err_bit_sel};
    assign flip_vec   = '0;
    assign err_flag   = '0;
    assign err_count  = '0;
`endif

    for (genvar c = 0; c < CH; c++) begin : g_lane
        macc_err_lane #(
            .IN_W  (IN_W),
            .ACC_W (ACC_W),
            .BIT_W (BIT_W)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_en    (ce & in_valid),
            .s2_en    (s2_en),
            .sload    (s1_sload),
            .a        (a[lane_lo(c, IN_W) +: IN_W]),
            .b        (b[lane_lo(c, IN_W) +: IN_W]),
            .flip_en  (flip_vec[c]),
            .flip_bit (err_bit_sel),
            .acc      (accum_out[lane_lo(c, ACC_W) +: ACC_W]),
            .ovf      (ovf[c])
        );
    end

endmodule
